// File: rtl/rom_arbiter.sv
// Two-port read arbiter/sequencer sharing one registered-read program ROM port.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin conflicts; otherwise port A has fixed priority.
module rom_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              rom_enable,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);
   localparam int STAGES = 2;

   // Stage 1 = ROM data phase, stage 2 = response; port id 1 means B.
   logic [STAGES:1]   vld_pipe;
   logic [STAGES:1]   port_pipe;
   logic [ADDR_W-1:0] addr_q;

`ifdef ROM_ARB_ROUND_ROBIN_EN
   logic last_b;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              last_b <= 1'b1;
      else if (a_gnt || b_gnt) last_b <= b_gnt;
   end

   assign a_gnt = a_req & (~b_req | last_b);
`else
   assign a_gnt = a_req;
`endif
   assign b_gnt = b_req & ~a_gnt;

   // Address is muxed straight through in the grant cycle; held when idle.
   assign rom_addr = a_gnt ? a_addr : (b_gnt ? b_addr : addr_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q    <= '0;
         vld_pipe  <= '0;
         port_pipe <= '0;
      end else begin
         addr_q    <= rom_addr;
         vld_pipe  <= {vld_pipe[STAGES-1:1], a_gnt | b_gnt};
         port_pipe <= {port_pipe[STAGES-1:1], b_gnt};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_rdata <= '0;
         b_rdata <= '0;
      end else if (vld_pipe[1]) begin
         if (port_pipe[1]) b_rdata <= rom_data;
         else              a_rdata <= rom_data;
      end
   end

   assign rom_enable = vld_pipe[1];
   assign a_rvalid   = vld_pipe[STAGES] & ~port_pipe[STAGES];
   assign b_rvalid   = vld_pipe[STAGES] &  port_pipe[STAGES];

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a small registered ROM model attached.
module tb_rom_arbiter;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              a_req = 1'b0, b_req = 1'b0;
   logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
   logic              a_gnt, b_gnt, a_rvalid, b_rvalid, rom_enable;
   logic [DATA_W-1:0] a_rdata, b_rdata, rom_data, rom_q;
   logic [ADDR_W-1:0] rom_addr;

   int checks = 0;
   int failures = 0;

   rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .rom_enable(rom_enable), .rom_addr(rom_addr), .rom_data(rom_data)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      case (a)
         14'h0000: rom_word = 16'h5341;
         14'h0001: rom_word = 16'h4D52;
         14'h0002: rom_word = 16'h2D3C;
         14'h0003: rom_word = 16'h2C3B;
         14'h0008: rom_word = 16'h8000;
         14'h0014: rom_word = 16'h0176;
         default:  rom_word = 16'h0000;
      endcase
   endfunction

   always @(posedge clk) rom_q <= rom_word(rom_addr);
   assign rom_data = rom_enable ? rom_q : '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Inputs change 1 after the rising edge; outputs sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   initial begin
      // reset state
      tick(); mid();
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_rom_en", rom_enable, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rdata", b_rdata, 0);
      tick(); reset = 1'b1;
      tick();

      // single A read of word 0
      a_req = 1'b1; a_addr = 14'h0000; mid();
      chk("single_a_gnt", a_gnt, 1);
      chk("single_b_gnt", b_gnt, 0);
      chk("single_rom_en0", rom_enable, 0);
      tick(); a_req = 1'b0; mid();
      chk("single_rom_en1", rom_enable, 1);
      chk("single_rvalid1", a_rvalid, 0);
      tick(); mid();
      chk("single_a_rvalid", a_rvalid, 1);
      chk("single_a_rdata", a_rdata, 16'h5341);
      chk("single_b_rvalid", b_rvalid, 0);
      chk("single_rom_en2", rom_enable, 0);
      tick(); mid();
      chk("single_rvalid_pulse", a_rvalid, 0);
      tick();

      // A streaming 0..3
      begin
         logic [DATA_W-1:0] exp_s [4];
         exp_s = '{16'h5341, 16'h4D52, 16'h2D3C, 16'h2C3B};
         for (int k = 0; k < 7; k++) begin
            a_req  = (k < 4);
            a_addr = (k < 4) ? ADDR_W'(k) : 14'h0003;
            mid();
            chk($sformatf("stream_gnt%0d", k), a_gnt, (k < 4));
            chk($sformatf("stream_rvalid%0d", k), a_rvalid, (k >= 2 && k < 6));
            if (k >= 2 && k < 6) chk($sformatf("stream_data%0d", k), a_rdata, exp_s[k-2]);
            tick();
         end
      end

      // B reads an unprogrammed word; A data untouched
      b_req = 1'b1; b_addr = 14'h3FFF; mid();
      chk("unprog_b_gnt", b_gnt, 1);
      chk("unprog_rom_addr", rom_addr, 14'h3FFF);
      tick(); b_req = 1'b0; tick(); mid();
      chk("unprog_b_rvalid", b_rvalid, 1);
      chk("unprog_b_rdata", b_rdata, 16'h0000);
      chk("unprog_a_rvalid", a_rvalid, 0);
      chk("unprog_a_rdata", a_rdata, 16'h2C3B);
      tick();

      // conflict A=0x0008, B=0x0014
      a_addr = 14'h0008; b_addr = 14'h0014;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < 7; k++) begin
         a_req = (k < 4); b_req = (k < 4);
         mid();
         chk($sformatf("rr_a_gnt%0d", k), a_gnt, (k < 4) && (k % 2 == 0));
         chk($sformatf("rr_b_gnt%0d", k), b_gnt, (k < 4) && (k % 2 == 1));
         chk($sformatf("rr_a_rvalid%0d", k), a_rvalid, (k >= 2 && k < 6) && (k % 2 == 0));
         chk($sformatf("rr_b_rvalid%0d", k), b_rvalid, (k >= 2 && k < 6) && (k % 2 == 1));
         if (k >= 2 && k < 6) begin
            if (k % 2 == 0) chk($sformatf("rr_a_data%0d", k), a_rdata, 16'h8000);
            else            chk($sformatf("rr_b_data%0d", k), b_rdata, 16'h0176);
         end
         tick();
      end
`else
      for (int k = 0; k < 8; k++) begin
         a_req = (k < 4); b_req = (k < 5);
         mid();
         chk($sformatf("fp_a_gnt%0d", k), a_gnt, (k < 4));
         chk($sformatf("fp_b_gnt%0d", k), b_gnt, (k == 4));
         chk($sformatf("fp_a_rvalid%0d", k), a_rvalid, (k >= 2 && k < 6));
         chk($sformatf("fp_b_rvalid%0d", k), b_rvalid, (k == 6));
         if (k >= 2 && k < 6) chk($sformatf("fp_a_data%0d", k), a_rdata, 16'h8000);
         if (k == 6)          chk("fp_b_data", b_rdata, 16'h0176);
         tick();
      end
`endif

      // reset mid-flight
      a_req = 1'b1; a_addr = 14'h0001; mid();
      chk("midrst_gnt", a_gnt, 1);
      tick(); a_req = 1'b0; reset = 1'b0; #1;
      chk("midrst_rom_en", rom_enable, 0);
      chk("midrst_a_rvalid", a_rvalid, 0);
      chk("midrst_rom_addr", rom_addr, 0);
      chk("midrst_a_rdata", a_rdata, 0);
      chk("midrst_b_rdata", b_rdata, 0);
      chk("midrst_gnts", {a_gnt, b_gnt}, 0);
      tick(); mid();
      chk("midrst_a_rvalid2", a_rvalid, 0);
      tick(); reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         mid();
         chk($sformatf("postrst_quiet%0d", k), {a_rvalid, b_rvalid, rom_enable}, 0);
         tick();
      end
      a_req = 1'b1; a_addr = 14'h0001; mid();
      chk("fresh_gnt", a_gnt, 1);
      tick(); a_req = 1'b0; tick(); mid();
      chk("fresh_rvalid", a_rvalid, 1);
      chk("fresh_rdata", a_rdata, 16'h4D52);
      tick();

      // idle for 10 cycles
      for (int k = 0; k < 10; k++) begin
         mid();
         chk($sformatf("idle_ctl%0d", k), {a_gnt, b_gnt, a_rvalid, b_rvalid, rom_enable}, 0);
         chk($sformatf("idle_addr%0d", k), rom_addr, 14'h0001);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
